gpio_ctrl: RTL
==============

# gpio_ctrl

Memory-mapped GPIO controller that owns the SoC's 24-bit bidirectional GPIO pad bank. It sits between the core's peripheral bus and the pad tri-state buffers in `soc_top`. It sequences register accesses through a request/acknowledge handshake, and configures pin direction and output value. It synchronises pad inputs and raises a level interrupt on selected pin edges, which feeds `irq_ext_i`.

## Interface
Parameters:
- `GPIO_W`, 24, number of GPIO pins (1..32).

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stb_i` in 1: bus request; held high until `ack_o`.
- `we_i` in 1: 1 = write, 0 = read; sampled with the request.
- `addr_i` in 5: byte address; `addr_i[4:2]` selects the register, `[1:0]` is ignored.
- `wdata_i` in 32: write data; bits above `GPIO_W` are ignored.
- `rdata_o` out 32: read data, valid only while `ack_o` = 1, otherwise 0.
- `ack_o` out 1: one-cycle transaction acknowledge.
- `gpio_i` in GPIO_W: raw pad input, asynchronous to `clk`.
- `gpio_o` out GPIO_W: pad output value.
- `gpio_oe_o` out GPIO_W: pad output enable (1 = drive).
- `irq_o` out 1: level interrupt, active high.

## Operation
Registers (`addr_i[4:2]`):
- 0 DATA_IN (RO): synchronised pin state.
- 1 DATA_OUT (RW): drives `gpio_o`.
- 2 DIR (RW): drives `gpio_oe_o`.
- 3 IRQ_EN (RW): per-pin interrupt enable.
- 4 IRQ_EDGE (RW): per pin, 0 = rising edge, 1 = falling edge.
- 5 IRQ_PEND (R/W1C): per-pin pending flag.
- 6–7: unmapped; reads return 0, writes are ignored, and the access is still acknowledged.

Bus FSM:
- States: IDLE, ACK.
- IDLE → ACK when `stb_i` = 1. Address, data and `we_i` are captured on this transition, and a write commits on the same edge.
- ACK → IDLE unconditionally. `ack_o` = 1 only in ACK, and `rdata_o` is registered from the captured address.
- Throughput: one transaction per two cycles. A request seen in ACK is not re-accepted until IDLE.

Input path:
- `gpio_i` passes through a 2-flop synchroniser to give `sync`.
- `sync_d` is `sync` delayed one cycle.
- Rising edge = `sync & ~sync_d`; falling edge = `~sync & sync_d`.

Pending update: `pend <= (pend & ~w1c_mask) | edge_hit`.
- `edge_hit` is the edge selected per pin by IRQ_EDGE.
- A new edge in the same cycle as a W1C of that bit leaves the bit set (set wins).
- Edges set PEND whether or not IRQ_EN is set; IRQ_EN masks only `irq_o`.

Interrupt output: `irq_o` is registered as `|(pend & irq_en)`.

Pins with DIR = 1 still sample their own pad value into DATA_IN and can trigger interrupts.

Reset (`rst` = 1, any time, including mid-transaction):
- All registers, synchroniser flops, `ack_o`, `rdata_o`, `gpio_o`, `gpio_oe_o` and `irq_o` go to 0, so all pins are inputs.
- The FSM goes to IDLE and any in-flight access is dropped without `ack_o`.

## Timing
- Write: request sampled at edge N; register updated and `ack_o` high after edge N; `gpio_o`/`gpio_oe_o` reflect the new value from edge N.
- Read: `ack_o` and `rdata_o` are valid in the cycle after edge N.
- Pin to DATA_IN: a pin change set up before edge k is visible in `sync` after edge k+1.
- Pin to PEND: the PEND bit sets at edge k+2.
- Pin to `irq_o`: `irq_o` asserts at edge k+3.
- W1C of the last enabled pending bit at edge N: `irq_o` deasserts at edge N+1.

## Configuration
- Macro `GPIO_IRQ_EN`.
- Defined: IRQ_EN, IRQ_EDGE, IRQ_PEND, the edge detector and `irq_o` are implemented as described above.
- Undefined: that logic is removed. Registers 3–5 read 0 and ignore writes, `irq_o` is tied to 0, and the synchroniser is still present for DATA_IN.

## Structure
- Package `gpio_ctrl_pkg`:
  - register index constants (`GPIO_REG_DATA_IN` … `GPIO_REG_IRQ_PEND`);
  - FSM state enum `gpio_bus_state_e` {IDLE, ACK}.
- Sub-module `gpio_sync`: parameterised-width 2-flop synchroniser with async active-high reset, instantiated once.

## Test plan
- Reset mid-read (`rst` pulsed in ACK) → no `ack_o` that cycle; all outputs 0; subsequent read of DIR returns 0.
- Write DIR = 0x00F0F0, then DATA_OUT = 0xA5A5A5 → `gpio_oe_o` = 0x00F0F0, `gpio_o` = 0xA5A5A5, each `ack_o` a single-cycle pulse; reads return the same values; reads of addresses 0x18 and 0x1C return 0.
- Drive `gpio_i` = 0x000001 asynchronously → DATA_IN read returns 0x1 only after 2 clocks; a read 1 cycle after the change returns 0.
- IRQ_EN = 0x1, IRQ_EDGE = 0: rise on pin 0 before edge k → PEND[0] = 1 at k+2, `irq_o` = 1 at k+3. Write PEND = 0x1 → `irq_o` = 0 one cycle after the write edge.
- IRQ_EDGE[3] = 1, IRQ_EN = 0: falling edge on pin 3 → PEND = 0x8, `irq_o` stays 0. Then set IRQ_EN = 0x8 → `irq_o` = 1.
- W1C of PEND[0] in the same cycle a new rising edge reaches PEND[0] → PEND[0] stays 1 and `irq_o` stays high. Without `GPIO_IRQ_EN`, the same stimulus leaves PEND reading 0 and `irq_o` = 0.

Source files
------------

// File: rtl/gpio_ctrl_pkg.sv
// Shared definitions for the GPIO controller: register map and bus FSM states.
package gpio_ctrl_pkg;
  localparam logic [2:0] GPIO_REG_DATA_IN  = 3'd0;
  localparam logic [2:0] GPIO_REG_DATA_OUT = 3'd1;
  localparam logic [2:0] GPIO_REG_DIR      = 3'd2;
  localparam logic [2:0] GPIO_REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] GPIO_REG_IRQ_EDGE = 3'd4;
  localparam logic [2:0] GPIO_REG_IRQ_PEND = 3'd5;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} gpio_bus_state_e;
endpackage

// File: rtl/gpio_ctrl_sync.sv
// Parameterised-width two-flop synchroniser for asynchronous pad inputs.
module gpio_sync #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller with edge interrupts.
// Interrupt logic (IRQ_EN/IRQ_EDGE/IRQ_PEND, irq_o) is built only when GPIO_IRQ_EN is defined.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int GPIO_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [4:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              ack_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe_o,
  output logic              irq_o
);
  gpio_bus_state_e   state;
  logic [GPIO_W-1:0] sync;
  logic [GPIO_W-1:0] wval;
  logic [2:0]        sel;
  logic              acc, wr;
  logic [31:0]       rd_mux;
  logic              unused_ok;

  assign sel       = addr_i[4:2];
  assign acc       = (state == IDLE) && stb_i;
  assign wr        = acc && we_i;
  assign wval      = wdata_i[GPIO_W-1:0];
  assign ack_o     = (state == ACK);
  assign unused_ok = ^{addr_i[1:0], wdata_i};

  gpio_sync #(.W(GPIO_W)) u_sync (.clk(clk), .rst(rst), .d(gpio_i), .q(sync));

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] irq_en, irq_edge, pend, sync_d, edge_hit, w1c_mask;

  // IRQ_EDGE picks falling (1) or rising (0) per pin; a fresh edge beats a same-cycle clear.
  assign edge_hit = (~irq_edge & sync & ~sync_d) | (irq_edge & ~sync & sync_d);
  assign w1c_mask = (wr && sel == GPIO_REG_IRQ_PEND) ? wval : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en   <= '0;
      irq_edge <= '0;
      pend     <= '0;
      sync_d   <= '0;
      irq_o    <= 1'b0;
    end else begin
      sync_d <= sync;
      pend   <= (pend & ~w1c_mask) | edge_hit;
      irq_o  <= |(pend & irq_en);
      if (wr && sel == GPIO_REG_IRQ_EN)   irq_en   <= wval;
      if (wr && sel == GPIO_REG_IRQ_EDGE) irq_edge <= wval;
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (sel)
      GPIO_REG_DATA_IN:  rd_mux[GPIO_W-1:0] = sync;
      GPIO_REG_DATA_OUT: rd_mux[GPIO_W-1:0] = gpio_o;
      GPIO_REG_DIR:      rd_mux[GPIO_W-1:0] = gpio_oe_o;
`ifdef GPIO_IRQ_EN
      GPIO_REG_IRQ_EN:   rd_mux[GPIO_W-1:0] = irq_en;
      GPIO_REG_IRQ_EDGE: rd_mux[GPIO_W-1:0] = irq_edge;
      GPIO_REG_IRQ_PEND: rd_mux[GPIO_W-1:0] = pend;
`endif
      default:           rd_mux = '0;
    endcase
  end

  // Read data is captured on the accept edge and held only for the ACK cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rdata_o   <= '0;
      gpio_o    <= '0;
      gpio_oe_o <= '0;
    end else begin
      case (state)
        IDLE: if (stb_i) begin
          state   <= ACK;
          rdata_o <= we_i ? 32'd0 : rd_mux;
        end
        default: begin
          state   <= IDLE;
          rdata_o <= '0;
        end
      endcase
      if (wr && sel == GPIO_REG_DATA_OUT) gpio_o    <= wval;
      if (wr && sel == GPIO_REG_DIR)      gpio_oe_o <= wval;
    end
  end
endmodule
